// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller and its time helpers.
// Optional feature macro used by the controller: ALARM_BEEP_EN.
package alarm_pkg;

  localparam int H_W = 5;
  localparam int M_W = 6;

  localparam logic [H_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [M_W-1:0] MIN_MAX  = 6'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZED = 2'd3
  } state_e;

  // True when an HH:MM pair is a legal time of day.
  function automatic logic time_valid(input logic [H_W-1:0] h, input logic [M_W-1:0] m);
    return (h <= HOUR_MAX) && (m <= MIN_MAX);
  endfunction

endpackage

// File: rtl/time_add_min.sv
// Adds a fixed number of minutes to an HH:MM value, carrying into the hour
// and wrapping 23 -> 0. Purely combinational so other time blocks can share it.
module time_add_min
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN = 5
) (
  input  logic [H_W-1:0] h_i,
  input  logic [M_W-1:0] m_i,
  output logic [H_W-1:0] h_o,
  output logic [M_W-1:0] m_o
);

  logic [6:0] m_sum_s;
  logic [6:0] m_wrap_s;

  // Minute sum with carry into the hour and midnight wrap.
  always_comb begin
    m_sum_s  = {1'b0, m_i} + 7'(SNOOZE_MIN);
    m_wrap_s = m_sum_s - 7'd60;
    if (m_sum_s >= 7'd60) begin
      m_o = m_wrap_s[M_W-1:0];
      if (h_i >= HOUR_MAX) begin
        h_o = 5'd0;
      end else begin
        h_o = h_i + 5'd1;
      end
    end else begin
      m_o = m_sum_s[M_W-1:0];
      h_o = h_i;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Single-alarm controller: compares the live time against a programmable
// target, rings for a bounded number of ticks, supports snooze and stop.
// Define ALARM_BEEP_EN to chop the ring output on alternate ticks.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_TICKS = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic [H_W-1:0] h_in,
  input  logic [M_W-1:0] m_in,
  input  logic [M_W-1:0] s_in,
  input  logic           arm_en,
  input  logic           set_valid,
  input  logic [H_W-1:0] set_h,
  input  logic [M_W-1:0] set_m,
  output logic           set_err,
  input  logic           snooze,
  input  logic           stop,
  output logic           ring,
  output logic [1:0]     state,
  output logic [2:0]     snooze_cnt
);

  state_e         state_q, state_d;
  logic           ring_q, ring_d;
  logic           set_err_q, set_err_d;
  logic [2:0]     snooze_cnt_q, snooze_cnt_d;
  logic [7:0]     ring_cnt_q, ring_cnt_d;
  logic [H_W-1:0] al_h_q, al_h_d, tgt_h_q, tgt_h_d;
  logic [M_W-1:0] al_m_q, al_m_d, tgt_m_q, tgt_m_d;
`ifdef ALARM_BEEP_EN
  logic           phase_q, phase_d;
`endif

  logic           match_s;
  logic           set_ok_s;
  logic [H_W-1:0] snz_h_s;
  logic [M_W-1:0] snz_m_s;

  assign match_s  = tick && (s_in == 6'd0) && (h_in == tgt_h_q) && (m_in == tgt_m_q);
  assign set_ok_s = time_valid(set_h, set_m);

  time_add_min #(.SNOOZE_MIN(SNOOZE_MIN)) u_snz_add (
    .h_i (tgt_h_q),
    .m_i (tgt_m_q),
    .h_o (snz_h_s),
    .m_o (snz_m_s)
  );

  // Next-state logic in priority order: disarm, set, stop, snooze, timeout, match.
  always_comb begin
    state_d      = state_q;
    set_err_d    = 1'b0;
    snooze_cnt_d = snooze_cnt_q;
    ring_cnt_d   = ring_cnt_q;
    al_h_d       = al_h_q;
    al_m_d       = al_m_q;
    tgt_h_d      = tgt_h_q;
    tgt_m_d      = tgt_m_q;

    if (!arm_en) begin
      // Disarm wins; a valid set still updates the stored alarm.
      state_d      = IDLE;
      snooze_cnt_d = 3'd0;
      if (set_valid && set_ok_s) begin
        al_h_d  = set_h;
        al_m_d  = set_m;
        tgt_h_d = set_h;
        tgt_m_d = set_m;
      end else begin
        tgt_h_d   = al_h_q;
        tgt_m_d   = al_m_q;
        set_err_d = set_valid;
      end
    end else if (set_valid) begin
      // A set consumes the cycle, so a coincident match is discarded.
      if (set_ok_s) begin
        al_h_d       = set_h;
        al_m_d       = set_m;
        tgt_h_d      = set_h;
        tgt_m_d      = set_m;
        snooze_cnt_d = 3'd0;
        state_d      = ARMED;
      end else begin
        set_err_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARMED;
        end
        ARMED: begin
          if (match_s) begin
            state_d    = RINGING;
            ring_cnt_d = 8'd0;
          end else begin
            state_d = ARMED;
          end
        end
        RINGING: begin
          if (stop) begin
            state_d      = ARMED;
            tgt_h_d      = al_h_q;
            tgt_m_d      = al_m_q;
            snooze_cnt_d = 3'd0;
          end else if (snooze && (snooze_cnt_q < 3'(MAX_SNOOZE))) begin
            state_d      = SNOOZED;
            snooze_cnt_d = snooze_cnt_q + 3'd1;
            tgt_h_d      = snz_h_s;
            tgt_m_d      = snz_m_s;
          end else if (tick) begin
            // An exhausted snooze falls through here and ringing continues.
            if (ring_cnt_q == 8'(RING_TICKS - 1)) begin
              state_d      = ARMED;
              tgt_h_d      = al_h_q;
              tgt_m_d      = al_m_q;
              snooze_cnt_d = 3'd0;
            end else begin
              ring_cnt_d = ring_cnt_q + 8'd1;
            end
          end else begin
            state_d = RINGING;
          end
        end
        SNOOZED: begin
          if (stop) begin
            state_d      = ARMED;
            tgt_h_d      = al_h_q;
            tgt_m_d      = al_m_q;
            snooze_cnt_d = 3'd0;
          end else if (match_s) begin
            state_d    = RINGING;
            ring_cnt_d = 8'd0;
          end else begin
            state_d = SNOOZED;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

`ifdef ALARM_BEEP_EN
    // Beep phase starts high on entry and flips every tick while ringing.
    if (state_d != RINGING) begin
      phase_d = 1'b1;
    end else if (state_q != RINGING) begin
      phase_d = 1'b1;
    end else if (tick) begin
      phase_d = ~phase_q;
    end else begin
      phase_d = phase_q;
    end
    ring_d = (state_d == RINGING) && phase_d;
`else
    ring_d = (state_d == RINGING);
`endif
  end

  // State and output registers; async reset silences the ring at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ring_q       <= 1'b0;
      set_err_q    <= 1'b0;
      snooze_cnt_q <= 3'd0;
      ring_cnt_q   <= 8'd0;
      al_h_q       <= 5'd0;
      al_m_q       <= 6'd0;
      tgt_h_q      <= 5'd0;
      tgt_m_q      <= 6'd0;
`ifdef ALARM_BEEP_EN
      phase_q      <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      ring_q       <= ring_d;
      set_err_q    <= set_err_d;
      snooze_cnt_q <= snooze_cnt_d;
      ring_cnt_q   <= ring_cnt_d;
      al_h_q       <= al_h_d;
      al_m_q       <= al_m_d;
      tgt_h_q      <= tgt_h_d;
      tgt_m_q      <= tgt_m_d;
`ifdef ALARM_BEEP_EN
      phase_q      <= phase_d;
`endif
    end
  end

  assign state      = state_q;
  assign ring       = ring_q;
  assign set_err    = set_err_q;
  assign snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with default parameters (60 ticks, 5 min, 3 snoozes).
// Expected ring values follow ALARM_BEEP_EN when it is defined.
module tb_alarm_ctrl;

`ifdef ALARM_BEEP_EN
  localparam bit BEEP = 1'b1;
`else
  localparam bit BEEP = 1'b0;
`endif

  logic       clk, rst_n, tick;
  logic [4:0] h_in, set_h;
  logic [5:0] m_in, s_in, set_m;
  logic       arm_en, set_valid, snooze, stop;
  logic       set_err, ring;
  logic [1:0] state;
  logic [2:0] snooze_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  alarm_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .h_in       (h_in),
    .m_in       (m_in),
    .s_in       (s_in),
    .arm_en     (arm_en),
    .set_valid  (set_valid),
    .set_h      (set_h),
    .set_m      (set_m),
    .set_err    (set_err),
    .snooze     (snooze),
    .stop       (stop),
    .ring       (ring),
    .state      (state),
    .snooze_cnt (snooze_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    h_in = h;
    m_in = m;
    s_in = s;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_set(input logic [4:0] h, input logic [5:0] m);
    set_h     = h;
    set_m     = m;
    set_valid = 1'b1;
    cyc();
    set_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b1; arm_en = 1'b0; set_valid = 1'b0;
    set_h = 5'd0; set_m = 6'd0; snooze = 1'b0; stop = 1'b0;
    set_time(5'd0, 6'd0, 6'd1);
    repeat (2) cyc();
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_ring", 8'(ring), 8'd0);
    chk("rst_set_err", 8'(set_err), 8'd0);
    chk("rst_snooze_cnt", 8'(snooze_cnt), 8'd0);
    rst_n = 1'b1;

    // 1: set 07:30, match at 07:30:00, ring the cycle after
    arm_en = 1'b1;
    set_time(5'd7, 6'd29, 6'd59);
    do_set(5'd7, 6'd30);
    chk("t1_armed", 8'(state), 8'd1);
    cyc();
    set_time(5'd7, 6'd30, 6'd0);
    chk("t1_no_ring_before", 8'(ring), 8'd0);
    cyc();
    set_time(5'd7, 6'd30, 6'd1);
    chk("t1_ring", 8'(ring), 8'd1);
    chk("t1_state_ringing", 8'(state), 8'd2);

    // 2: auto-stop after 60 ticks
    repeat (59) cyc();
    chk("t2_still_ringing", 8'(state), 8'd2);
    chk("t2_ring_59", 8'(ring), BEEP ? 8'd0 : 8'd1);
    cyc();
    chk("t2_timeout_state", 8'(state), 8'd1);
    chk("t2_timeout_ring", 8'(ring), 8'd0);
    set_time(5'd7, 6'd30, 6'd0);
    cyc();
    set_time(5'd7, 6'd30, 6'd1);
    chk("t2_tgt_reloaded", 8'(state), 8'd2);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t2_stop", 8'(state), 8'd1);

    // 3: alarm 23:58, snooze wraps target to 00:03
    do_set(5'd23, 6'd58);
    set_time(5'd23, 6'd58, 6'd0);
    cyc();
    set_time(5'd23, 6'd58, 6'd1);
    chk("t3_ringing", 8'(state), 8'd2);
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    chk("t3_snoozed", 8'(state), 8'd3);
    chk("t3_snooze_cnt", 8'(snooze_cnt), 8'd1);
    chk("t3_ring_off", 8'(ring), 8'd0);
    set_time(5'd0, 6'd2, 6'd59);
    cyc();
    chk("t3_no_early", 8'(state), 8'd3);
    set_time(5'd0, 6'd3, 6'd0);
    cyc();
    set_time(5'd0, 6'd3, 6'd1);
    chk("t3_resume_state", 8'(state), 8'd2);
    chk("t3_resume_ring", 8'(ring), 8'd1);

    // 4: snoozes 2 and 3, fourth ignored, stop beats snooze
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk("t4_cnt2", 8'(snooze_cnt), 8'd2);
    set_time(5'd0, 6'd8, 6'd0); cyc(); set_time(5'd0, 6'd8, 6'd1);
    chk("t4_ring_0008", 8'(state), 8'd2);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk("t4_cnt3", 8'(snooze_cnt), 8'd3);
    set_time(5'd0, 6'd13, 6'd0); cyc(); set_time(5'd0, 6'd13, 6'd1);
    chk("t4_ring_0013", 8'(ring), 8'd1);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk("t4_fourth_ignored_state", 8'(state), 8'd2);
    chk("t4_fourth_ignored_ring", 8'(ring), BEEP ? 8'd0 : 8'd1);
    chk("t4_fourth_cnt", 8'(snooze_cnt), 8'd3);
    stop = 1'b1; snooze = 1'b1; cyc(); stop = 1'b0; snooze = 1'b0;
    chk("t4_stop_wins_state", 8'(state), 8'd1);
    chk("t4_stop_wins_cnt", 8'(snooze_cnt), 8'd0);
    chk("t4_stop_ring", 8'(ring), 8'd0);

    // 5: rejected sets, then disarm mid-ring
    do_set(5'd24, 6'd10);
    chk("t5_err_hour", 8'(set_err), 8'd1);
    chk("t5_err_hour_state", 8'(state), 8'd1);
    cyc();
    chk("t5_err_pulse_end", 8'(set_err), 8'd0);
    do_set(5'd10, 6'd60);
    chk("t5_err_min", 8'(set_err), 8'd1);
    set_time(5'd23, 6'd58, 6'd0);
    cyc();
    set_time(5'd23, 6'd58, 6'd1);
    chk("t5_alarm_unchanged", 8'(state), 8'd2);
    arm_en = 1'b0;
    cyc();
    chk("t5_disarm_ring", 8'(ring), 8'd0);
    chk("t5_disarm_state", 8'(state), 8'd0);
    arm_en = 1'b1;
    cyc();
    chk("t5_rearm", 8'(state), 8'd1);

    // 6: ring pattern across ticks, then async reset mid-ring
    set_time(5'd23, 6'd58, 6'd0);
    cyc();
    set_time(5'd23, 6'd58, 6'd1);
    chk("t6_ring_tick0", 8'(ring), 8'd1);
    cyc();
    chk("t6_ring_tick1", 8'(ring), BEEP ? 8'd0 : 8'd1);
    cyc();
    chk("t6_ring_tick2", 8'(ring), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_ring", 8'(ring), 8'd0);
    chk("t6_async_state", 8'(state), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Downstream consumer of the 24-hour H:M:S time-of-day counter.
- Holds one programmable alarm time (HH:MM) and compares it against the live time.
- Drives a ring output with bounded duration, snooze (limited count, fixed minute offset) and stop.
- Feeds the buzzer driver and status LEDs.

Parameters:
RING_TICKS, 60, ticks the alarm rings before auto-stop (1..255)
SNOOZE_MIN, 5, minutes added to the current target per snooze (1..59)
MAX_SNOOZE, 3, max snoozes per alarm event (1..7)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick  input  1  time advanced this cycle (tie 1 when the counter steps every clk)
h_in  input  5  current hour 0..23
m_in  input  6  current minute 0..59
s_in  input  6  current second 0..59
arm_en  input  1  level; 1 = alarm enabled
set_valid  input  1  one-cycle load strobe for the alarm time
set_h  input  5  alarm hour
set_m  input  6  alarm minute
set_err  output  1  one-cycle pulse: set rejected (out of range)
snooze  input  1  one-cycle snooze request
stop  input  1  one-cycle stop request
ring  output  1  alarm sounding
state  output  2  0 IDLE, 1 ARMED, 2 RINGING, 3 SNOOZED
snooze_cnt  output  3  snoozes used in the current event

Behaviour:
- Reset values:
  - Outputs: state=IDLE, ring=0, set_err=0, snooze_cnt=0.
  - Internal: al_h/al_m=0, tgt_h/tgt_m=0, ring_cnt=0.
- All outputs are registered.
- Match condition: tick && s_in==0 && h_in==tgt_h && m_in==tgt_m.
- ring=1 exactly while state==RINGING. It asserts the cycle after the match cycle.
- Set handling (any state, arm_en=1):
  - Accepted when set_h<=23 && set_m<=59.
  - On accept: al and tgt load with set_h/set_m, snooze_cnt clears, state goes to ARMED next cycle.
  - Otherwise: set_err pulses next cycle and nothing else changes.
- IDLE: go to ARMED when arm_en=1. A set accepted with arm_en=0 updates al/tgt and stays IDLE.
- ARMED: on match, go to RINGING and clear ring_cnt.
- RINGING:
  - ring_cnt increments on each tick.
  - Timeout: tick with ring_cnt==RING_TICKS-1 -> ARMED, tgt<=al, snooze_cnt<=0.
  - stop -> ARMED, same reload.
  - snooze with snooze_cnt<MAX_SNOOZE -> SNOOZED, snooze_cnt+1, tgt<=tgt+SNOOZE_MIN minutes.
  - snooze with snooze_cnt==MAX_SNOOZE is ignored and ringing continues.
- SNOOZED: on match, go to RINGING and clear ring_cnt; stop -> ARMED with reload.
- Minute addition:
  - m_sum = tgt_m + SNOOZE_MIN (7-bit).
  - If m_sum>=60: minute = m_sum-60, hour+1. Hour 23+1 wraps to 0.
- Priority, highest first:
  - arm_en=0 forces IDLE (ring drops next cycle; al is kept, tgt reloads from al, snooze_cnt clears).
  - then set_valid
  - then stop
  - then snooze
  - then timeout
  - then match
- snooze or stop in IDLE/ARMED is ignored.
- Async reset mid-ring drops ring immediately.
- A match that coincides with an accepted set is discarded. The new target is used from the next cycle.

Optional Feature:
- Macro: ALARM_BEEP_EN.
- Defined:
  - ring is gated by a beep phase flop that toggles on every tick while RINGING.
  - Phase is 1 on entry, so ring alternates 1/0 per tick, starting at 1.
- Undefined: ring is steady while RINGING.

Decomposition:
- Package alarm_pkg holds:
  - state enum: IDLE, ARMED, RINGING, SNOOZED
  - constants HOUR_MAX=23, MIN_MAX=59
  - width constants H_W=5, M_W=6
- One natural combinational sub-module: time_add_min.
  - Inputs: h, m, fixed SNOOZE_MIN.
  - Outputs: wrapped h/m.
  - Reused by the future time-set block.

Test Plan:
1. Reset, arm_en=1, set 07:30, drive time 07:29:59 -> 07:30:00 with tick -> ring=1 one cycle after the 07:30:00 match cycle, state=2.
2. Ringing, no input, RING_TICKS=60 -> ring falls after 60 ticks; state=ARMED; tgt back to 07:30.
3. Alarm 23:58, SNOOZE_MIN=5, snooze while ringing -> state=SNOOZED, snooze_cnt=1; ring resumes at 00:03:00.
4. Three snoozes accepted, fourth snooze at snooze_cnt=3 ignored (ring stays 1); stop and snooze in the same cycle -> stop wins, state=ARMED, snooze_cnt=0.
5. set_h=24, set_m=10 -> set_err pulse, alarm unchanged; set_m=60 -> set_err pulse; arm_en=0 mid-ring -> ring=0 next cycle, state=IDLE.
6. With ALARM_BEEP_EN defined, ring alternates 1,0,1 on successive ticks during RINGING; undefined build holds 1; assert rst_n low mid-ring -> ring=0 immediately.
